// File: rtl/card_dealer.sv
// Deck buffer between the shuffler and the game controller.
// Captures the shuffled stream, deals one decoded card per request and flags a low shoe.
module card_dealer #(
  parameter int DECK_SIZE    = 52,
  parameter int RESHUFFLE_AT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       card_valid,
  input  logic [5:0] card_in,
  input  logic       load_done,
  input  logic       deal_req,
  output logic       deck_ready,
  output logic       deal_valid,
  output logic [5:0] deal_card,
  output logic [1:0] deal_suit,
  output logic [3:0] deal_rank,
  output logic [3:0] deal_points,
  output logic       deal_is_ace,
  output logic       deal_err,
  output logic [5:0] remaining,
  output logic       shuffle_req
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_EMPTY = 2'd2;

  localparam logic [5:0] DECK_N   = 6'(DECK_SIZE);
  localparam logic [5:0] LOW_MARK = 6'(RESHUFFLE_AT);
  localparam logic [5:0] SUIT_LEN = 6'd13;

  logic [1:0] state_reg;
  logic [5:0] wp_reg;
  logic [5:0] rp_reg;
  logic [5:0] deck [DECK_SIZE];

  logic       code_ok;
  logic       load_wr;
  logic       restart_wr;
  logic [5:0] wr_addr;
  logic [5:0] wp_inc;
  logic [5:0] rd_data;

  assign code_ok    = (card_in < DECK_N);
  assign load_wr    = (state_reg == ST_LOAD) && card_valid && code_ok && (wp_reg < DECK_N);
  assign restart_wr = (state_reg == ST_EMPTY) && card_valid && code_ok;
  assign wr_addr    = restart_wr ? 6'd0 : wp_reg;
  assign wp_inc     = wp_reg + 6'd1;
  assign rd_data    = deck[rp_reg];

  always_ff @(posedge clk) begin
    if (load_wr || restart_wr) begin
      deck[wr_addr] <= card_in;
    end
  end

  // Suit/rank by repeated subtraction of 13; at most three steps cover 0..51.
  logic [5:0] dec_rem;
  logic [1:0] dec_suit;
  logic [3:0] dec_rank;
  logic [3:0] dec_points;
  logic       unused_rem_bits;

  always_comb begin
    dec_rem  = rd_data;
    dec_suit = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (dec_rem >= SUIT_LEN) begin
        dec_rem  = dec_rem - SUIT_LEN;
        dec_suit = dec_suit + 2'd1;
      end
    end
    dec_rank = dec_rem[3:0];
    if (dec_rank == 4'd0) begin
      dec_points = 4'd11;
    end else if (dec_rank >= 4'd10) begin
      dec_points = 4'd10;
    end else begin
      dec_points = dec_rank + 4'd1;
    end
  end

  assign unused_rem_bits = ^dec_rem[5:4];

  assign remaining   = (state_reg == ST_LOAD) ? 6'd0 : (wp_reg - rp_reg);
  assign deck_ready  = (state_reg == ST_READY);
  assign shuffle_req = (state_reg == ST_EMPTY) ||
                       ((state_reg == ST_READY) && (remaining < LOW_MARK));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_LOAD;
      wp_reg      <= 6'd0;
      rp_reg      <= 6'd0;
      deal_valid  <= 1'b0;
      deal_err    <= 1'b0;
      deal_card   <= 6'd0;
      deal_suit   <= 2'd0;
      deal_rank   <= 4'd0;
      deal_points <= 4'd0;
      deal_is_ace <= 1'b0;
    end else begin
      deal_valid <= 1'b0;
      deal_err   <= 1'b0;
      case (state_reg)
        ST_LOAD: begin
          if (deal_req) begin
            deal_err <= 1'b1;
          end
          if (load_wr) begin
            wp_reg <= wp_inc;
          end
          if (load_wr && (wp_inc == DECK_N)) begin
            state_reg <= ST_READY;
          end else if (load_done) begin
            // A short deck with nothing in it has nothing to deal.
            state_reg <= (load_wr || (wp_reg != 6'd0)) ? ST_READY : ST_EMPTY;
          end
        end
        ST_READY: begin
          if (remaining == 6'd0) begin
            state_reg <= ST_EMPTY;
          end else if (deal_req) begin
            deal_valid  <= 1'b1;
            deal_card   <= rd_data;
            deal_suit   <= dec_suit;
            deal_rank   <= dec_rank;
            deal_points <= dec_points;
            deal_is_ace <= (dec_rank == 4'd0);
            rp_reg      <= rp_reg + 6'd1;
            if (remaining == 6'd1) begin
              state_reg <= ST_EMPTY;
            end
          end
        end
        ST_EMPTY: begin
          if (deal_req) begin
            deal_err <= 1'b1;
          end
          if (restart_wr) begin
            wp_reg    <= 6'd1;
            rp_reg    <= 6'd0;
            state_reg <= ST_LOAD;
          end
        end
        default: begin
          state_reg <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the shoe.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       card_valid = 1'b0;
  logic [5:0] card_in = 6'd0;
  logic       load_done = 1'b0;
  logic       deal_req = 1'b0;
  logic       deck_ready, deal_valid, deal_is_ace, deal_err, shuffle_req;
  logic [5:0] deal_card, remaining;
  logic [1:0] deal_suit;
  logic [3:0] deal_rank, deal_points;

  card_dealer #(.DECK_SIZE(52), .RESHUFFLE_AT(15)) dut (
    .clk(clk), .rst(rst), .card_valid(card_valid), .card_in(card_in),
    .load_done(load_done), .deal_req(deal_req), .deck_ready(deck_ready),
    .deal_valid(deal_valid), .deal_card(deal_card), .deal_suit(deal_suit),
    .deal_rank(deal_rank), .deal_points(deal_points), .deal_is_ace(deal_is_ace),
    .deal_err(deal_err), .remaining(remaining), .shuffle_req(shuffle_req)
  );

  always #5 clk = ~clk;

  int total_checks = 0;
  int passed_checks = 0;
  int cycle = 0;

  // Model: 0 = loading, 1 = ready to deal, 2 = empty; shoe holds undealt cards in order.
  int m_mode = 0;
  int shoe[$];
  int e_valid = 0, e_err = 0, e_card = 0, e_suit = 0, e_rank = 0, e_pts = 0, e_ace = 0;

  function automatic void chk(string name, int act, int exp);
    total_checks++;
    if (act == exp) passed_checks++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
  endfunction

  function automatic void model(bit r, bit cv, int cin, bit ld, bit dr);
    if (r) begin
      m_mode = 0; shoe.delete();
      e_valid = 0; e_err = 0; e_card = 0; e_suit = 0; e_rank = 0; e_pts = 0; e_ace = 0;
      return;
    end
    e_valid = 0; e_err = 0;
    case (m_mode)
      0: begin
        if (dr) e_err = 1;
        if (cv && cin < 52 && shoe.size() < 52) shoe.push_back(cin);
        if (shoe.size() == 52) m_mode = 1;
        else if (ld) m_mode = (shoe.size() > 0) ? 1 : 2;
      end
      1: begin
        if (dr) begin
          e_card = shoe.pop_front();
          e_valid = 1;
          e_suit = e_card / 13;
          e_rank = e_card % 13;
          e_pts = (e_rank == 0) ? 11 : ((e_rank >= 10) ? 10 : e_rank + 1);
          e_ace = (e_rank == 0) ? 1 : 0;
          if (shoe.size() == 0) m_mode = 2;
        end
      end
      default: begin
        if (dr) e_err = 1;
        if (cv && cin < 52) begin
          shoe.delete(); shoe.push_back(cin); m_mode = 0;
        end
      end
    endcase
  endfunction

  function automatic void compare();
    int rem;
    rem = (m_mode == 0) ? 0 : shoe.size();
    chk("deck_ready", int'(deck_ready), (m_mode == 1) ? 1 : 0);
    chk("remaining", int'(remaining), rem);
    chk("shuffle_req", int'(shuffle_req), (m_mode == 2 || (m_mode == 1 && rem < 15)) ? 1 : 0);
    chk("deal_valid", int'(deal_valid), e_valid);
    chk("deal_err", int'(deal_err), e_err);
    chk("deal_card", int'(deal_card), e_card);
    chk("deal_suit", int'(deal_suit), e_suit);
    chk("deal_rank", int'(deal_rank), e_rank);
    chk("deal_points", int'(deal_points), e_pts);
    chk("deal_is_ace", int'(deal_is_ace), e_ace);
  endfunction

  task automatic step(input bit r, input bit cv, input int cin, input bit ld, input bit dr);
    rst = r; card_valid = cv; card_in = 6'(cin); load_done = ld; deal_req = dr;
    @(posedge clk);
    model(r, cv, cin & 63, ld, dr);
    #1;
    cycle++;
    compare();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_ready"}, int'(deck_ready), 0);
    chk({tag, "_remaining"}, int'(remaining), 0);
    chk({tag, "_valid"}, int'(deal_valid), 0);
    chk({tag, "_err"}, int'(deal_err), 0);
    chk({tag, "_shuffle"}, int'(shuffle_req), 0);
    chk({tag, "_fields"}, {deal_card, deal_suit, deal_rank, deal_points, deal_is_ace}, 0);
  endtask

  task automatic load_perm(input bit gaps);
    int p[52];
    int j, t;
    for (int i = 0; i < 52; i++) p[i] = i;
    for (int i = 51; i > 0; i--) begin
      j = $urandom_range(0, i); t = p[i]; p[i] = p[j]; p[j] = t;
    end
    for (int i = 0; i < 52; i++) begin
      step(0, 1, p[i], 0, 0);
      if (gaps && $urandom_range(0, 1) == 1) idle();
    end
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check_all_zero("lit_reset");

    // Full deck 51..0, one strobe every other cycle.
    for (int i = 0; i < 52; i++) begin
      step(0, 1, 51 - i, 0, 0);
      if (i == 51) begin
        chk("lit_ready_after_52", int'(deck_ready), 1);
        chk("lit_remaining_52", int'(remaining), 52);
        chk("lit_shuffle_full", int'(shuffle_req), 0);
      end else begin
        idle();
      end
    end

    // 52 back-to-back deals.
    for (int i = 0; i < 52; i++) begin
      step(0, 0, 0, 0, 1);
      chk("lit_deal_card", int'(deal_card), 51 - i);
      chk("lit_deal_valid", int'(deal_valid), 1);
      if (51 - i == 0)
        chk("lit_code0", {deal_suit, deal_rank, deal_points, deal_is_ace}, {2'd0, 4'd0, 4'd11, 1'b1});
      if (51 - i == 25)
        chk("lit_code25", {deal_suit, deal_rank, deal_points, deal_is_ace}, {2'd1, 4'd12, 4'd10, 1'b0});
      if (51 - i == 40)
        chk("lit_code40", {deal_suit, deal_rank, deal_points, deal_is_ace}, {2'd3, 4'd1, 4'd2, 1'b0});
      if (i == 36) chk("lit_shuffle_at_15", int'(shuffle_req), 0);
      if (i == 37) chk("lit_shuffle_at_14", int'(shuffle_req), 1);
    end
    step(0, 0, 0, 0, 1);
    chk("lit_53rd_err", int'(deal_err), 1);
    chk("lit_53rd_valid", int'(deal_valid), 0);

    // Deal request and card strobe together while empty: error and new load.
    step(0, 1, $urandom_range(0, 51), 0, 1);
    chk("lit_empty_err", int'(deal_err), 1);
    for (int i = 0; i < 9; i++) step(0, 1, $urandom_range(0, 51), 0, 0);
    step(0, 0, 0, 0, 1);
    chk("lit_load_err", int'(deal_err), 1);
    step(0, 1, 60, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, $urandom_range(0, 51), 0, 0);
    step(0, 0, 0, 1, 0);
    chk("lit_short_ready", int'(deck_ready), 1);
    chk("lit_short_remaining", int'(remaining), 20);
    chk("lit_short_shuffle", int'(shuffle_req), 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, $urandom_range(0, 51), 0, 1);
      if (i == 4) chk("lit_short_shuffle_15", int'(shuffle_req), 0);
    end
    chk("lit_short_remaining_14", int'(remaining), 14);
    chk("lit_short_shuffle_14", int'(shuffle_req), 1);

    step(1, 0, 0, 0, 0);
    check_all_zero("lit_rst_mid_deal");

    for (int i = 0; i < 30; i++) step(0, 1, $urandom_range(0, 51), 0, 0);
    step(1, 0, 0, 0, 0);
    check_all_zero("lit_rst_mid_load");

    load_perm(0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    load_perm(1);
    for (int n = 0; n < 200 && m_mode != 2; n++)
      step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 63), 0, $urandom_range(0, 2) != 0);
    chk("lit_drained", int'(shuffle_req), 1);

    // Random traffic, including invalid codes, short decks and stray resets.
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 63),
           $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
